// File: rtl/mem_stream_demux.sv
// Receive end of the merged memory stream: decodes the destination index of each word and
// writes its payload to one of NMEM memories. Optional parity check: define STREAM_PARITY_EN.
module mem_stream_demux #(
    parameter int NMEM = 12,
    parameter int DW   = 45,
    parameter int AW   = 6,
    parameter int BXW  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_event,
    input  logic [BXW-1:0]      BX,
    input  logic [53:0]         stream_dat,
    input  logic                valid_in,
    input  logic                done_in,
    output logic [NMEM-1:0]     wr_en,
    output logic [BXW+AW-1:0]   wr_addr,
    output logic [DW-1:0]       wr_dat,
    output logic [NMEM*AW-1:0]  number_out,
    output logic                cnt_valid,
    output logic [NMEM-1:0]     ovf,
    output logic                dest_err,
    output logic                parity_err
);

    localparam logic [AW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [BXW-1:0]  bx_q;
    logic [AW-1:0]   count [NMEM];

    logic [3:0]      dest;
    logic [NMEM-1:0] dest_hit;
    logic [AW-1:0]   cur_cnt;
    logic            dest_ok;
    logic            in_run;
    logic            par_bad;
    logic            try_write;
    logic            accept;
    logic            ovf_set;
    logic            derr_set;
    logic            unused_bits;

    assign dest = stream_dat[DW +: 4];

`ifdef STREAM_PARITY_EN
    // Even parity: bit DW+4 makes the XOR of the whole checked field zero.
    assign par_bad     = ^stream_dat[DW+4:0];
    assign unused_bits = ^stream_dat[53:DW+5];
`else
    assign par_bad     = 1'b0;
    assign unused_bits = ^stream_dat[53:DW+4];
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dest_hit = '0;
        cur_cnt  = '0;
        for (int i = 0; i < NMEM; i++) begin
            if (dest == 4'(i)) begin
                dest_hit[i] = 1'b1;
                cur_cnt     = count[i];
            end
        end
    end

    assign dest_ok   = |dest_hit;
    // A word arriving together with new_event belongs to neither event and is dropped.
    assign in_run    = (state == RUN) && !new_event;
    assign try_write = in_run && valid_in && !par_bad && dest_ok;
    assign accept    = try_write && (cur_cnt != CNT_MAX);
    assign ovf_set   = try_write && (cur_cnt == CNT_MAX);
    assign derr_set  = valid_in && (!in_run || (!par_bad && !dest_ok));

    always_comb begin
        state_nxt = state;
        if (new_event) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (done_in) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared by reset like any register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx_q       <= '0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_dat     <= '0;
            number_out <= '0;
            cnt_valid  <= 1'b0;
            ovf        <= '0;
            dest_err   <= 1'b0;
            for (int i = 0; i < NMEM; i++) count[i] <= '0;
        end else begin
            wr_en     <= accept ? dest_hit : '0;
            cnt_valid <= new_event;
            if (accept) begin
                wr_addr <= {bx_q, cur_cnt};
                wr_dat  <= stream_dat[DW-1:0];
            end
            if (new_event) begin
                bx_q     <= BX;
                ovf      <= '0;
                dest_err <= valid_in;
                for (int i = 0; i < NMEM; i++) begin
                    number_out[i*AW +: AW] <= count[i];
                    count[i]               <= '0;
                end
            end else begin
                ovf      <= ovf | ({NMEM{ovf_set}} & dest_hit);
                dest_err <= dest_err | derr_set;
                for (int i = 0; i < NMEM; i++) begin
                    if (accept && dest_hit[i]) count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

`ifdef STREAM_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (new_event) begin
            parity_err <= 1'b0;
        end else if (in_run && valid_in && par_bad) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stream_demux.sv
// Self-checking bench for mem_stream_demux: reference model feeding a write scoreboard,
// a vector table for back-to-back traffic, and hand sequences for overflow/reset/parity.
module tb_mem_stream_demux;

    localparam int NMEM = 12;
    localparam int DW   = 45;
    localparam int AW   = 6;
    localparam int BXW  = 3;

`ifdef STREAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                new_event = 1'b0;
    logic [BXW-1:0]      BX = '0;
    logic [53:0]         stream_dat = '0;
    logic                valid_in = 1'b0;
    logic                done_in = 1'b0;
    logic [NMEM-1:0]     wr_en;
    logic [BXW+AW-1:0]   wr_addr;
    logic [DW-1:0]       wr_dat;
    logic [NMEM*AW-1:0]  number_out;
    logic                cnt_valid;
    logic [NMEM-1:0]     ovf;
    logic                dest_err;
    logic                parity_err;

    mem_stream_demux #(.NMEM(NMEM), .DW(DW), .AW(AW), .BXW(BXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_event  (new_event),
        .BX         (BX),
        .stream_dat (stream_dat),
        .valid_in   (valid_in),
        .done_in    (done_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_dat     (wr_dat),
        .number_out (number_out),
        .cnt_valid  (cnt_valid),
        .ovf        (ovf),
        .dest_err   (dest_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [NMEM-1:0]    en;
        logic [BXW+AW-1:0]  addr;
        logic [DW-1:0]      dat;
    } wr_t;
    wr_t sb[$];

    // Reference model state
    int                 m_cnt [NMEM];
    logic [BXW-1:0]     m_bx;
    int                 m_state;   // 0 idle, 1 run, 2 done
    logic [NMEM-1:0]    m_ovf;
    bit                 m_derr, m_perr, m_cv;
    logic [NMEM*AW-1:0] m_num;

    task automatic model_reset();
        for (int i = 0; i < NMEM; i++) m_cnt[i] = 0;
        m_bx = '0; m_state = 0; m_ovf = '0;
        m_derr = 0; m_perr = 0; m_cv = 0; m_num = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, then compare DUT outputs #1 after the edge.
    task automatic step(input bit ne, input logic [BXW-1:0] bx, input bit vld, input int dest,
                        input logic [DW-1:0] pay, input bit done, input bit badp);
        logic [3:0] d4;
        logic       p;
        wr_t        w;
        wr_t        e;
        d4 = 4'(dest);
        p  = (^{d4, pay}) ^ badp;
        new_event  = ne;
        BX         = bx;
        valid_in   = vld;
        done_in    = done;
        stream_dat = {4'b0000, p, d4, pay};

        w.en = '0; w.addr = '0; w.dat = '0;
        if (ne) begin
            for (int i = 0; i < NMEM; i++) begin
                m_num[i*AW +: AW] = AW'(m_cnt[i]);
                m_cnt[i] = 0;
            end
            m_bx = bx; m_ovf = '0; m_derr = vld; m_perr = 0; m_cv = 1; m_state = 1;
        end else begin
            m_cv = 0;
            if (vld) begin
                if (m_state != 1) m_derr = 1;
                else if (PAR_EN && badp) m_perr = 1;
                else if (dest >= NMEM) m_derr = 1;
                else if (m_cnt[dest] == 63) m_ovf[dest] = 1'b1;
                else begin
                    w.en   = NMEM'(1) << dest;
                    w.addr = {m_bx, AW'(m_cnt[dest])};
                    w.dat  = pay;
                    m_cnt[dest]++;
                end
            end
            if (m_state == 1 && done) m_state = 2;
        end
        sb.push_back(w);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("wr_en", wr_en, e.en);
        if (e.en != '0) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_dat", wr_dat, e.dat);
        end
        check("cnt_valid", cnt_valid, m_cv);
        check("number_out", number_out, m_num);
        check("ovf", ovf, m_ovf);
        check("dest_err", dest_err, m_derr);
        check("parity_err", parity_err, PAR_EN ? m_perr : 1'b0);
        new_event = 0; valid_in = 0; done_in = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, '0);
        check({tag, "_wr_addr"}, wr_addr, '0);
        check({tag, "_wr_dat"}, wr_dat, '0);
        check({tag, "_number_out"}, number_out, '0);
        check({tag, "_cnt_valid"}, cnt_valid, 1'b0);
        check({tag, "_ovf"}, ovf, '0);
        check({tag, "_dest_err"}, dest_err, 1'b0);
        check({tag, "_parity_err"}, parity_err, 1'b0);
    endtask

    typedef struct {
        bit              ne;
        bit              vld;
        int              dest;
        logic [NMEM-1:0] exp_en;
        logic [AW-1:0]   exp_lo;
        bit              exp_derr;
    } vec_t;

    initial begin
        vec_t vecs[4];
        vecs[0] = '{ne: 1, vld: 1, dest: 1, exp_en: 12'h000, exp_lo: 6'd0, exp_derr: 1};
        vecs[1] = '{ne: 0, vld: 1, dest: 1, exp_en: 12'h002, exp_lo: 6'd0, exp_derr: 1};
        vecs[2] = '{ne: 0, vld: 1, dest: 4, exp_en: 12'h010, exp_lo: 6'd0, exp_derr: 1};
        vecs[3] = '{ne: 0, vld: 1, dest: 1, exp_en: 12'h002, exp_lo: 6'd1, exp_derr: 1};

        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 0;

        // Idle word before any event: dropped
        step(0, 0, 1, 2, 45'h1, 0, 0);
        check("idle_drop_derr", dest_err, 1'b1);

        // Event BX=5, three words to memory 2
        step(1, 3'd5, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 2, 45'(64'h1000 + i), 0, 0);
            check("t1_addr", wr_addr, 9'h140 + 9'(i));
        end
        step(0, 0, 0, 0, '0, 0, 0);
        step(1, 3'd1, 0, 0, '0, 0, 0);
        check("t1_cnt_valid", cnt_valid, 1'b1);
        check("t1_num2", number_out[2*AW +: AW], 6'd3);
        check("t1_num_rest", number_out & ~({{(NMEM*AW-AW){1'b0}}, {AW{1'b1}}} << (2*AW)), '0);
        step(0, 0, 0, 0, '0, 0, 0);
        check("t1_cnt_valid_pulse", cnt_valid, 1'b0);

        // 64 words to memory 0: last is an overflow
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 45'($urandom), 0, 0);
        check("t2_ovf0", ovf[0], 1'b1);
        step(1, 3'd2, 0, 0, '0, 0, 0);
        check("t2_num0", number_out[0 +: AW], 6'd63);
        check("t2_ovf_clear", ovf, '0);

        // Invalid destination, then done, then late word
        step(0, 0, 1, 13, 45'h55, 0, 0);
        check("t3_no_wr", wr_en, '0);
        check("t3_derr", dest_err, 1'b1);
        step(1, 3'd3, 0, 0, '0, 0, 0);
        step(0, 0, 1, 7, 45'h77, 1, 0);      // done with valid: accepted
        check("t3_done_valid_wr", wr_en, 12'h080);
        step(0, 0, 1, 7, 45'h78, 0, 0);      // after done: dropped
        check("t3_after_done", wr_en, '0);
        check("t3_after_done_derr", dest_err, 1'b1);
        step(1, 3'd4, 0, 0, '0, 1, 0);       // new_event beats done
        step(0, 0, 1, 5, 45'h99, 0, 0);
        check("t3_ne_beats_done", wr_en, 12'h020);

        // Vector table: word on new_event cycle, then back-to-back traffic
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].ne, 3'd2, vecs[i].vld, vecs[i].dest, 45'(i + 1), 0, 0);
            check("t4_wr_en", wr_en, vecs[i].exp_en);
            if (vecs[i].exp_en != '0) check("t4_addr_lo", wr_addr[AW-1:0], vecs[i].exp_lo);
            check("t4_derr", dest_err, vecs[i].exp_derr);
        end

        // Asynchronous reset mid-event after 5 writes
        step(1, 3'd6, 0, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 3, 45'(i + 9), 0, 0);
        #2;
        reset = 1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 0;
        step(0, 0, 1, 3, 45'h3, 0, 0);
        check("t5_idle_drop", wr_en, '0);
        check("t5_idle_derr", dest_err, 1'b1);

        // Parity: bad word written only when the check is compiled out
        step(1, 3'd7, 0, 0, '0, 0, 0);
        step(0, 0, 1, 3, 45'h1234, 0, 1);
        check("t6_par_wr_en", wr_en, PAR_EN ? 12'h000 : 12'h008);
        check("t6_parity_err", parity_err, PAR_EN);
        step(0, 0, 1, 3, 45'h4321, 0, 0);
        check("t6_good_wr_en", wr_en, 12'h008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
